// File: rtl/vga_scan_controller.sv
// Pixel scan sequencer: divides the system clock to pixel rate and walks horizontal and
// vertical timing FSMs, producing registered x/y, active, sync and start pulses.
module vga_scan_controller #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        enable,
   output logic                        pixel_tick,
   output logic [$clog2(H_ACTIVE)-1:0] x,
   output logic [$clog2(V_ACTIVE)-1:0] y,
   output logic                        active,
   output logic                        hsync,
   output logic                        vsync,
   output logic                        line_start,
   output logic                        frame_start
);

   localparam int unsigned XW      = $clog2(H_ACTIVE);
   localparam int unsigned YW      = $clog2(V_ACTIVE);
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HCW     = $clog2(H_TOTAL);
   localparam int unsigned VCW     = $clog2(V_TOTAL);
   localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0]  DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [HCW-1:0] H_ACT_LAST = HCW'(H_ACTIVE - 1);
   localparam logic [HCW-1:0] H_FP_LAST  = HCW'(H_FP - 1);
   localparam logic [HCW-1:0] H_SY_LAST  = HCW'(H_SYNC - 1);
   localparam logic [HCW-1:0] H_BP_LAST  = HCW'(H_BP - 1);
   localparam logic [VCW-1:0] V_ACT_LAST = VCW'(V_ACTIVE - 1);
   localparam logic [VCW-1:0] V_FP_LAST  = VCW'(V_FP - 1);
   localparam logic [VCW-1:0] V_SY_LAST  = VCW'(V_SYNC - 1);
   localparam logic [VCW-1:0] V_BP_LAST  = VCW'(V_BP - 1);

   // Shared phase encoding for both the horizontal and vertical FSMs.
   localparam logic [1:0] ST_ACT  = 2'd0;
   localparam logic [1:0] ST_FP   = 2'd1;
   localparam logic [1:0] ST_SYNC = 2'd2;
   localparam logic [1:0] ST_BP   = 2'd3;

   if (CLK_DIV == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_FP == 0 || V_SYNC == 0 || V_BP == 0 || H_ACTIVE < 2 || V_ACTIVE < 2)
   begin : g_param_check
      $error("vga_scan_controller: CLK_DIV, porch and sync lengths must be nonzero");
   end

   function automatic logic [1:0] next_phase(input logic [1:0] s);
      logic [1:0] n;
      case (s)
         ST_ACT:  n = ST_FP;
         ST_FP:   n = ST_SYNC;
         ST_SYNC: n = ST_BP;
         default: n = ST_ACT;
      endcase
      return n;
   endfunction

   logic [DW-1:0]  div_q, div_d;
   logic           tick;
   logic [1:0]     h_state_q, h_state_d, v_state_q, v_state_d;
   logic [HCW-1:0] h_cnt_q, h_cnt_d, h_last;
   logic [VCW-1:0] v_cnt_q, v_cnt_d, v_last;
   logic           h_end, v_end, line_end, frame_wrap;
   logic [XW-1:0]  x_d;
   logic [YW-1:0]  y_d;
   logic           active_d, hsync_d, vsync_d;

   always_comb begin
      tick  = enable && (div_q == DIV_LAST);
      div_d = div_q;
      if (enable) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      end
   end

   always_comb begin
      case (h_state_q)
         ST_ACT:  h_last = H_ACT_LAST;
         ST_FP:   h_last = H_FP_LAST;
         ST_SYNC: h_last = H_SY_LAST;
         default: h_last = H_BP_LAST;
      endcase
      h_end     = (h_cnt_q == h_last);
      h_state_d = h_state_q;
      h_cnt_d   = h_cnt_q;
      if (tick) begin
         if (h_end) begin
            h_cnt_d   = '0;
            h_state_d = next_phase(h_state_q);
         end else begin
            h_cnt_d = h_cnt_q + HCW'(1);
         end
      end
      line_end = tick && h_end && (h_state_q == ST_BP);
   end

   // Vertical FSM advances once per line, on the tick that leaves horizontal back porch.
   always_comb begin
      case (v_state_q)
         ST_ACT:  v_last = V_ACT_LAST;
         ST_FP:   v_last = V_FP_LAST;
         ST_SYNC: v_last = V_SY_LAST;
         default: v_last = V_BP_LAST;
      endcase
      v_end     = (v_cnt_q == v_last);
      v_state_d = v_state_q;
      v_cnt_d   = v_cnt_q;
      if (line_end) begin
         if (v_end) begin
            v_cnt_d   = '0;
            v_state_d = next_phase(v_state_q);
         end else begin
            v_cnt_d = v_cnt_q + VCW'(1);
         end
      end
      frame_wrap = line_end && v_end && (v_state_q == ST_BP);
   end

   always_comb begin
      active_d = (h_state_d == ST_ACT) && (v_state_d == ST_ACT);
      x_d      = (h_state_d == ST_ACT) ? h_cnt_d[XW-1:0] : '0;
      y_d      = (v_state_d == ST_ACT) ? v_cnt_d[YW-1:0] : '0;
      hsync_d  = (h_state_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d  = (v_state_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
   end

   // Reset parks both FSMs on their last back-porch slot so the first tick lands on (0,0).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_q     <= '0;
         h_state_q <= ST_BP;
         h_cnt_q   <= H_BP_LAST;
         v_state_q <= ST_BP;
         v_cnt_q   <= V_BP_LAST;
      end else begin
         div_q     <= div_d;
         h_state_q <= h_state_d;
         h_cnt_q   <= h_cnt_d;
         v_state_q <= v_state_d;
         v_cnt_q   <= v_cnt_d;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pixel_tick  <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         x           <= '0;
         y           <= '0;
         active      <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
      end else begin
         pixel_tick  <= tick;
         line_start  <= line_end;
         frame_start <= frame_wrap;
         if (tick) begin
            x      <= x_d;
            y      <= y_d;
            active <= active_d;
            hsync  <= hsync_d;
            vsync  <= vsync_d;
         end
      end
   end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: three configurations checked every cycle against an
// arithmetic model of tick index -> (column, line), plus directed literal expectations.
module tb_vga_scan_controller;

   typedef struct packed {
      logic        tick;
      logic [15:0] x;
      logic [15:0] y;
      logic        act;
      logic        hs;
      logic        vs;
      logic        ls;
      logic        fs;
   } obs_t;

   localparam obs_t RESET_A = {1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam obs_t FIRST_A = {1'b1, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam obs_t FIRST_B = {1'b1, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   localparam obs_t FROZEN  = {1'b0, 16'd100, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   logic clock = 1'b0;
   logic reset_n;
   logic enable;

   logic       a_tick, a_act, a_hs, a_vs, a_ls, a_fs;
   logic [9:0] a_x;
   logic [8:0] a_y;
   logic       b_tick, b_act, b_hs, b_vs, b_ls, b_fs;
   logic [1:0] b_x, b_y;
   logic       c_tick, c_act, c_hs, c_vs, c_ls, c_fs;
   logic [2:0] c_x, c_y;

   obs_t got_a, got_b, got_c;
   assign got_a = {a_tick, 16'(a_x), 16'(a_y), a_act, a_hs, a_vs, a_ls, a_fs};
   assign got_b = {b_tick, 16'(b_x), 16'(b_y), b_act, b_hs, b_vs, b_ls, b_fs};
   assign got_c = {c_tick, 16'(c_x), 16'(c_y), c_act, c_hs, c_vs, c_ls, c_fs};

   int errors = 0;
   int checks = 0;
   int ecnt;
   bit inc_last;

   always #5 clock = ~clock;

   vga_scan_controller dut_a (
      .clock(clock), .reset_n(reset_n), .enable(enable), .pixel_tick(a_tick),
      .x(a_x), .y(a_y), .active(a_act), .hsync(a_hs), .vsync(a_vs),
      .line_start(a_ls), .frame_start(a_fs)
   );

   vga_scan_controller #(
      .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
   ) dut_b (
      .clock(clock), .reset_n(reset_n), .enable(enable), .pixel_tick(b_tick),
      .x(b_x), .y(b_y), .active(b_act), .hsync(b_hs), .vsync(b_vs),
      .line_start(b_ls), .frame_start(b_fs)
   );

   vga_scan_controller #(
      .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
   ) dut_c (
      .clock(clock), .reset_n(reset_n), .enable(enable), .pixel_tick(c_tick),
      .x(c_x), .y(c_y), .active(c_act), .hsync(c_hs), .vsync(c_vs),
      .line_start(c_ls), .frame_start(c_fs)
   );

   // Enabled clock edges since reset; every dv-th one is a pixel tick.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ecnt     <= 0;
         inc_last <= 1'b0;
      end else begin
         inc_last <= enable;
         if (enable) ecnt <= ecnt + 1;
      end
   end

   function automatic obs_t model(input int en_cnt, input bit inc, input int dv,
                                  input int ha, input int hfp, input int hsw, input int hbp,
                                  input int va, input int vfp, input int vsw, input int vbp,
                                  input bit pol);
      obs_t o;
      int   n, p, l, ht, vt;
      bit   tk;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      o = '0;
      o.hs = !pol;
      o.vs = !pol;
      if (en_cnt < dv) return o;
      n  = en_cnt / dv - 1;
      tk = inc && (en_cnt % dv == 0);
      p  = n % ht;
      l  = (n / ht) % vt;
      o.tick = tk;
      if (p < ha) o.x = 16'(p);
      if (l < va) o.y = 16'(l);
      o.act = (p < ha) && (l < va);
      o.hs  = (p >= ha + hfp && p < ha + hfp + hsw) ? pol : !pol;
      o.vs  = (l >= va + vfp && l < va + vfp + vsw) ? pol : !pol;
      o.ls  = tk && (p == 0);
      o.fs  = tk && (p == 0) && (l == 0);
      return o;
   endfunction

   task automatic check_obs(input string nm, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got tick=%0b x=%0d y=%0d act=%0b hs=%0b vs=%0b ls=%0b fs=%0b, expected tick=%0b x=%0d y=%0d act=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
                  nm, $time, got.tick, got.x, got.y, got.act, got.hs, got.vs, got.ls, got.fs,
                  exp.tick, exp.x, exp.y, exp.act, exp.hs, exp.vs, exp.ls, exp.fs);
      end
   endtask

   task automatic check_int(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      check_obs("model_a", got_a, model(ecnt, inc_last, 2, 640, 16, 96, 48, 480, 10, 2, 33, 0));
      check_obs("model_b", got_b, model(ecnt, inc_last, 1, 4, 1, 1, 1, 3, 1, 1, 1, 1));
      check_obs("model_c", got_c, model(ecnt, inc_last, 3, 8, 2, 3, 2, 5, 1, 2, 3, 0));
   endtask

   task automatic first_tick(input string tag);
      step();
      check_int({tag, "_a_no_tick_yet"}, int'(got_a.tick), 0);
      check_obs({tag, "_b_first_tick"}, got_b, FIRST_B);
      step();
      check_obs({tag, "_a_first_tick"}, got_a, FIRST_A);
   endtask

   task automatic wait_a_x(input int xv, input int budget, input string nm);
      int found = 0;
      for (int i = 0; i < budget && found == 0; i++) begin
         step();
         if (got_a.tick && got_a.x == 16'(xv)) found = 1;
      end
      check_int(nm, found, 1);
   endtask

   initial begin : main
      int t, x1, first_hs, hs_cnt, act_cnt, period, pulses, found;
      int fs1, fs2, ls_per, vs_first, vs_cnt, hs_first, cf1, cf2;

      reset_n = 1'b0;
      enable  = 1'b0;
      repeat (3) step();
      check_obs("reset_a", got_a, RESET_A);
      reset_n = 1'b1;
      enable  = 1'b1;
      first_tick("s1");

      // One full default line starting at tick 0 of the frame.
      t = 0; x1 = -1; first_hs = -1; hs_cnt = 0; act_cnt = 1; period = -1;
      for (int i = 0; i < 1700 && period < 0; i++) begin
         step();
         if (got_a.tick) begin
            t++;
            if (t == 1) x1 = int'(got_a.x);
            if (got_a.ls) period = t;
            else begin
               if (got_a.act) act_cnt++;
               if (!got_a.hs) begin
                  hs_cnt++;
                  if (first_hs < 0) first_hs = t;
               end
            end
         end
      end
      check_int("s2_x_at_tick1", x1, 1);
      check_int("s2_line_period", period, 800);
      check_int("s2_active_ticks", act_cnt, 640);
      check_int("s2_hsync_first", first_hs, 656);
      check_int("s2_hsync_width", hs_cnt, 96);

      // Freeze at x=100 of line 1.
      wait_a_x(100, 400, "s4_reach_x100");
      enable = 1'b0;
      pulses = 0;
      repeat (37) begin
         step();
         if (got_a.tick || got_a.ls || got_a.fs || got_b.tick || got_c.tick) pulses++;
      end
      check_int("s4_pulses_while_frozen", pulses, 0);
      check_obs("s4_frozen_a", got_a, FROZEN);
      enable = 1'b1;
      found = -1;
      for (int i = 0; i < 10 && found < 0; i++) begin
         step();
         if (got_a.tick) found = int'(got_a.x);
      end
      check_int("s4_resume_x", found, 101);

      // Reset in the middle of a visible line.
      wait_a_x(300, 800, "s5_reach_x300");
      #3 reset_n = 1'b0;
      #1 check_obs("s5_reset_immediate", got_a, RESET_A);
      repeat (2) step();
      reset_n = 1'b1;
      first_tick("s5");

      // Small config: one clock per pixel, 7-tick lines, 42-tick frames.
      fs1 = -1; fs2 = -1; ls_per = -1; vs_first = -1; vs_cnt = 0; hs_first = -1;
      for (int c = 0; c < 100 && fs2 < 0; c++) begin
         step();
         if (got_b.fs) begin
            if (fs1 < 0) fs1 = c;
            else fs2 = c;
         end
         if (fs1 >= 0 && fs2 < 0) begin
            if (got_b.ls && c > fs1 && ls_per < 0) ls_per = c - fs1;
            if (got_b.hs && hs_first < 0) hs_first = c - fs1;
            if (got_b.vs) begin
               vs_cnt++;
               if (vs_first < 0) vs_first = c - fs1;
            end
         end
      end
      check_int("s6_frame_period", fs2 - fs1, 42);
      check_int("s6_line_period", ls_per, 7);
      check_int("s6_hsync_tick", hs_first, 5);
      check_int("s6_vsync_first", vs_first, 28);
      check_int("s6_vsync_ticks", vs_cnt, 7);

      // Divide-by-3 config: 15 x 11 ticks per frame.
      cf1 = -1; cf2 = -1;
      for (int c = 0; c < 1200 && cf2 < 0; c++) begin
         step();
         if (got_c.fs) begin
            if (cf1 < 0) cf1 = c;
            else cf2 = c;
         end
      end
      check_int("c_frame_period_clocks", cf2 - cf1, 495);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
